mux_2to1: RTL and testbench
===========================

# mux_2to1

Two-input, WIDTH-bit selector with a registered output stage. The select a0 chooses between data inputs x1 and x0, and the result is presented on f one clock after capture. It sits in datapath steering logic wherever a clean, glitch-free, reset-defined selected value is needed. A bypass parameter turns the output stage into a purely combinational path.

## Interface
Parameters:
- WIDTH, default 1: data width of x1, x0 and f.
- OUT_REG, default 1: 1 selects the registered output; 0 selects combinational f, with f_vld still registered.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- en, input, 1: capture enable for the output register.
- a0, input, 1: select. 1 chooses x1, 0 chooses x0.
- x1, input, WIDTH: data input chosen when a0=1.
- x0, input, WIDTH: data input chosen when a0=0.
- f, output, WIDTH: selected data.
- f_vld, output, 1: f holds a value captured since the last reset.

## Operation
- Selection function: sel = a0 ? x1 : x0, evaluated bitwise across WIDTH.
- Unknown select (X/Z on a0), simulation semantics:
  - Each bit of sel is the common value where x1 and x0 agree on that bit.
  - Each bit of sel is X where they differ.
  - Example: a0=X, x1=1, x0=0 gives f=X.
- Unknown data: an X on the selected input propagates to f. An X on the unselected input does not affect f.
- OUT_REG=1:
  - Rising clk with en=1: f <= sel, f_vld <= 1.
  - Rising clk with en=0: f and f_vld hold.
- OUT_REG=0:
  - f = sel continuously.
  - f_vld behaves exactly as in OUT_REG=1.
- The block has no other state.

## Timing
- Reset:
  - rst_n low forces f=0 (registered mode) and f_vld=0 immediately, independent of clk.
  - Deassertion is synchronous to clk. The first capture occurs on the first rising edge with rst_n high and en=1.
- Latency:
  - OUT_REG=1: one clock from inputs to f.
  - OUT_REG=0: zero clocks, combinational.
- Changes between edges:
  - Changes on a0, x1 and x0 between edges are ignored in registered mode.
  - Only the values present at the rising edge are captured.
- Simultaneous events:
  - Reset asserted on a clock edge: reset wins, f=0 and f_vld=0.
  - en and an input change on the same edge: the pre-edge input values are captured.
- Reset mid-operation: f and f_vld clear at once. The previously captured value is lost.
- Throughput: one new selection per clock when en=1.

## Test plan
- Reset: hold rst_n=0 with a0=1, x1=1, x0=0 and toggle clk. Required: f=0 and f_vld=0 throughout. Release rst_n with en=1; after one edge, f=1 and f_vld=1.
- Exhaustive truth table (WIDTH=1, en=1): walk all 8 combinations of {a0,x1,x0} from 000 to 111. One edge after each, f must equal x0 when a0=0 and x1 when a0=1. Required sequence: 0,1,0,1,0,0,1,1.
- X handling:
  - a0=0, x1=X, x0=X: f=X.
  - a0=X, x1=1, x0=0: f=X.
  - a0=X, x1=1, x0=1: f=1.
  - a0=1, x1=0, x0=X: f=0.
- Enable hold: capture a0=1, x1=1 so that f=1. Set en=0, then drive a0=0, x0=0 for 3 edges; f must stay 1. Raise en; after the next edge, f=0.
- Async reset mid-stream: with f=1, pulse rst_n low between edges. f and f_vld must drop to 0 without a clock edge.
- Width and bypass:
  - WIDTH=8, OUT_REG=0, x1=8'hA5, x0=8'h3C: toggling a0 gives f=A5 and 3C combinationally.
  - Same stimulus with OUT_REG=1: f follows one clock later.

Source files
------------

// File: rtl/mux_2to1.sv
// WIDTH-bit two-input selector with an optional registered output stage.
// f_vld marks that at least one value has been captured since reset.
module mux_2to1 #(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x0,
    output logic [WIDTH-1:0] f,
    output logic             f_vld
);

    logic [WIDTH-1:0] w_sel;
    logic             r_vld;

    // An unknown select merges x1 and x0 bit by bit: agreeing bits pass, differing bits go X.
    assign w_sel = a0 ? x1 : x0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
        end else if (en) begin
            r_vld <= 1'b1;
        end
    end

    assign f_vld = r_vld;

    generate
        if (OUT_REG) begin : g_reg
            logic [WIDTH-1:0] r_f;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_f <= '0;
                end else if (en) begin
                    r_f <= w_sel;
                end
            end

            assign f = r_f;
        end else begin : g_comb
            assign f = w_sel;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: directed plan steps followed by random
// vectors scored against a bitwise selection model.
module tb_mux_2to1;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       a0;
    logic       x1_1, x0_1;
    logic [7:0] x1_8, x0_8;
    logic       f_1;
    logic [7:0] f_8r, f_8c;
    logic       vld_1, vld_8r, vld_8c;

    int n_vec = 0;
    int n_bad = 0;

    logic       exp_1;
    logic [7:0] exp_8r;
    logic       exp_vld;

    mux_2to1 #(.WIDTH(1), .OUT_REG(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .en(en), .a0(a0),
        .x1(x1_1), .x0(x0_1), .f(f_1), .f_vld(vld_1)
    );

    mux_2to1 #(.WIDTH(8), .OUT_REG(1'b1)) u_w8r (
        .clk(clk), .rst_n(rst_n), .en(en), .a0(a0),
        .x1(x1_8), .x0(x0_8), .f(f_8r), .f_vld(vld_8r)
    );

    mux_2to1 #(.WIDTH(8), .OUT_REG(1'b0)) u_w8c (
        .clk(clk), .rst_n(rst_n), .en(en), .a0(a0),
        .x1(x1_8), .x0(x0_8), .f(f_8c), .f_vld(vld_8c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference selection: known select picks a side, unknown select keeps only agreeing bits.
    function automatic logic [7:0] sel_model(input logic a, input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (a === 1'b1)      r[i] = hi[i];
            else if (a === 1'b0) r[i] = lo[i];
            else                 r[i] = (hi[i] === lo[i]) ? hi[i] : 1'bx;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] tt;
        logic [7:0] m;

        // Reset held with a0=1, x1=1, x0=0 while the clock runs.
        rst_n = 1'b0; en = 1'b1; a0 = 1'b1; x1_1 = 1'b1; x0_1 = 1'b0;
        x1_8 = 8'hA5; x0_8 = 8'h3C;
        #2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_f",     {7'b0, f_1},   8'h00);
            check("rst_vld",   {7'b0, vld_1}, 8'h00);
            check("rst_f8r",   f_8r,          8'h00);
            check("rst_vld8c", {7'b0, vld_8c}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_f",   {7'b0, f_1},   8'h01);
        check("rel_vld", {7'b0, vld_1}, 8'h01);

        // Exhaustive WIDTH=1 truth table; expected sequence 0,1,0,1,0,0,1,1.
        for (int i = 0; i < 8; i++) begin
            tt = 3'(i);
            {a0, x1_1, x0_1} = tt;
            m = sel_model(a0, {7'b0, x1_1}, {7'b0, x0_1});
            step();
            check($sformatf("tt%0d", i), {7'b0, f_1}, {7'b0, m[0]});
        end

        // Unknown select and unknown data.
        a0 = 1'b0; x1_1 = 1'bx; x0_1 = 1'bx;
        m = sel_model(a0, {7'b0, x1_1}, {7'b0, x0_1});
        step(); check("x_data_sel", {7'b0, f_1}, {7'b0, m[0]});
        a0 = 1'bx; x1_1 = 1'b1; x0_1 = 1'b0;
        m = sel_model(a0, {7'b0, x1_1}, {7'b0, x0_1});
        step(); check("x_sel_diff", {7'b0, f_1}, {7'b0, m[0]});
        a0 = 1'bx; x1_1 = 1'b1; x0_1 = 1'b1;
        step(); check("x_sel_same", {7'b0, f_1}, 8'h01);
        a0 = 1'b1; x1_1 = 1'b0; x0_1 = 1'bx;
        step(); check("x_unsel", {7'b0, f_1}, 8'h00);

        // Enable hold.
        a0 = 1'b1; x1_1 = 1'b1; x0_1 = 1'b0;
        step(); check("hold_load", {7'b0, f_1}, 8'h01);
        en = 1'b0; a0 = 1'b0; x0_1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); check($sformatf("hold%0d", i), {7'b0, f_1}, 8'h01);
        end
        en = 1'b1;
        step(); check("hold_release", {7'b0, f_1}, 8'h00);

        // Asynchronous reset between edges.
        a0 = 1'b1; x1_1 = 1'b1;
        step(); check("pre_async", {7'b0, f_1}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("async_f",    {7'b0, f_1},    8'h00);
        check("async_vld",  {7'b0, vld_1},  8'h00);
        check("async_f8r",  f_8r,           8'h00);
        check("async_vld8", {7'b0, vld_8r}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Bypass versus registered at WIDTH=8.
        x1_8 = 8'hA5; x0_8 = 8'h3C; a0 = 1'b1;
        #1; check("comb_a5", f_8c, 8'hA5);
        step(); check("reg_a5", f_8r, 8'hA5);
        a0 = 1'b0;
        #1; check("comb_3c", f_8c, 8'h3C);
        check("reg_lag", f_8r, 8'hA5);
        step(); check("reg_3c", f_8r, 8'h3C);

        // Random vectors with a scoreboard for the registered instances.
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_1 = 1'b0; exp_8r = 8'h00; exp_vld = 1'b0;
        for (int i = 0; i < 60; i++) begin
            a0   = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 3) != 0);
            x1_1 = 1'($urandom_range(0, 1));
            x0_1 = 1'($urandom_range(0, 1));
            x1_8 = 8'($urandom);
            x0_8 = 8'($urandom);
            #1; check("rnd_comb", f_8c, sel_model(a0, x1_8, x0_8));
            if (en) begin
                m       = sel_model(a0, {7'b0, x1_1}, {7'b0, x0_1});
                exp_1   = m[0];
                exp_8r  = sel_model(a0, x1_8, x0_8);
                exp_vld = 1'b1;
            end
            step();
            check("rnd_f1",  {7'b0, f_1},    {7'b0, exp_1});
            check("rnd_f8r", f_8r,           exp_8r);
            check("rnd_vld", {7'b0, vld_8c}, {7'b0, exp_vld});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
